rgb888_packer: RTL and testbench
================================

# rgb888_packer

Packs a stream of 24-bit RGB888 pixels into 32-bit CSI-2 payload words, three words per four pixels, in the byte order the `rgb888` unpacker consumes. It sits on the transmit path, between the pixel source and the CSI-2 packet builder / lane distributor. It supports valid/ready back-pressure on both sides. An optional flush terminates each line with a zero-padded partial word.

## Interface
- `PAD_BYTE`, default 8'h00: value placed in unused bytes of a flushed partial word.
- `clock` input, 1 bit: single clock; all logic on its rising edge.
- `reset_n` input, 1 bit: synchronous, active-low reset.
- `pixel` input, 24 bits: pixel; byte 0 on the wire is `pixel[7:0]`, then `[15:8]`, then `[23:16]`.
- `pixel_valid` input, 1 bit: `pixel`/`pixel_last` valid.
- `pixel_last` input, 1 bit: last pixel of the line.
- `pixel_ready` output, 1 bit: packer accepts a pixel this cycle.
- `word` output, 32 bits: packed payload word; byte 0 is `word[7:0]`.
- `word_valid` output, 1 bit: `word` valid.
- `word_last` output, 1 bit: final word of the line.
- `word_ready` input, 1 bit: downstream accepts `word`.

## Operation
- A pixel is accepted when `pixel_valid && pixel_ready`. A word is taken when `word_valid && word_ready`.
- State: `phase` (2 bits, 0..3) and `residual` (24 bits holding up to 3 carried bytes, `r`). Control FSM states: RUN and FLUSH.
- Packing per accepted pixel p in RUN:
  - phase 0: `r <= p`; no word.
  - phase 1: emit `{p[7:0], r[23:0]}`; `r[15:0] <= p[23:8]`.
  - phase 2: emit `{p[15:0], r[15:0]}`; `r[7:0] <= p[23:16]`.
  - phase 3: emit `{p[23:0], r[7:0]}`; residual empty.
  - `phase` increments and wraps 3 -> 0.
- Reference vector: pixels 0x030201, 0x060504, 0x090807, 0x0C0B0A give words 0x04030201, 0x08070605, 0x0C0B0A09.
- `pixel_ready = (state == RUN) && (!word_valid || word_ready)`.
- Line end (`pixel_last` accepted) is governed by the Configuration macro. In both builds `phase` returns to 0 for the next line.
- Reset: `word_valid=0`, `word_last=0`, `word=0`, `phase=0`, `residual=0`, state RUN. `pixel_ready` is 1 in the first cycle after reset release.
- Reset asserted mid-line or during FLUSH discards the residual and any pending word. No partial word is emitted.

## Timing
- Registered output: a word appears on `word` one cycle after the accepting edge.
- `word`, `word_valid` and `word_last` are held stable while `word_valid && !word_ready`.
- With `word_ready` held high, the packer sustains 1 pixel/cycle: 3 words per 4 cycles.
- A FLUSH costs exactly one extra cycle with `pixel_ready=0`, plus any back-pressure stall.
- When a word is taken and a pixel is accepted on the same edge, the register reloads (or clears `word_valid` if the new pixel produces no word). There is no bubble.

## Configuration
- `RGB888_PACKER_PAD_EN` defined: line-end flush is enabled. On an accepted `pixel_last`:
  - phase 0: emit `{PAD_BYTE, p}` with `word_last=1`.
  - phase 1: emit the normal word, then enter FLUSH. FLUSH emits `{PAD_BYTE, PAD_BYTE, p[23:8]}` with `word_last=1`.
  - phase 2: emit the normal word, then enter FLUSH. FLUSH emits `{PAD_BYTE x3, p[23:16]}` with `word_last=1`.
  - phase 3: emit the normal word with `word_last=1`.
  - FLUSH returns to RUN once the flush word is loaded.
- `RGB888_PACKER_PAD_EN` undefined: no FLUSH state.
  - `pixel_last` sets `word_last` on the word produced by that pixel, if any.
  - Any residual bytes are discarded.
  - Lines are required to be a multiple of 4 pixels. Other lengths give a truncated line with `word_last` possibly absent, and this is not flagged.

## Test plan
- Reset: hold `reset_n=0` for 3 cycles -> `word_valid=0`, `word_last=0`, `word=0`. First cycle after release -> `pixel_ready=1`.
- Streaming: 8 pixels 0x030201 … 0x181716 with `word_ready=1` -> exactly 6 words, starting 0x04030201, 0x08070605, 0x0C0B0A09. No stalls.
- Back-pressure: `word_ready=0` for 5 cycles mid-stream -> `word` is held unchanged and `pixel_ready=0`. Releasing it resumes with no lost or duplicated bytes.
- PAD_EN, 5-pixel line (last pixel 0x0F0E0D) -> 4th word 0x000F0E0D with `word_last=1`.
- PAD_EN, 6-pixel line (last pixel 0x121110) -> words 0x100F0E0D then 0x00001211 (`word_last=1`). `pixel_ready=0` during FLUSH. The next line starts at phase 0.
- Reset mid-line after 2 pixels -> no word emitted. The next line packs from phase 0 with correct words.

Source files
------------

// File: rtl/rgb888_packer.sv
// rgb888_packer: packs 24-bit RGB888 pixels into 32-bit CSI-2 payload words (4 pixels -> 3 words).
// Define RGB888_PACKER_PAD_EN to close each line with a PAD_BYTE-filled partial word.
module rgb888_packer #(
    parameter logic [7:0]   PAD_BYTE = 8'h00,
    localparam int unsigned PIX_W    = 24,
    localparam int unsigned WORD_W   = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [PIX_W-1:0]  pixel,
    input  logic              pixel_valid,
    input  logic              pixel_last,
    output logic              pixel_ready,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    output logic              word_last,
    input  logic              word_ready
);

    logic [1:0]        phase;
    logic [PIX_W-1:0]  residual;
    logic              out_free;
    logic              accept;
    logic              emit;
    logic [WORD_W-1:0] norm_word;
    logic [PIX_W-1:0]  next_residual;

    // Output register can take a new word when empty or being drained this cycle.
    assign out_free = !word_valid || word_ready;

`ifdef RGB888_PACKER_PAD_EN
    typedef enum logic {RUN, FLUSH} state_t;
    state_t            state;
    logic [WORD_W-1:0] flush_word;

    assign pixel_ready = (state == RUN) && out_free;

    // Phase was already advanced past the last pixel: 2 means two bytes carried, 3 means one.
    always_comb begin
        flush_word = {PAD_BYTE, PAD_BYTE, PAD_BYTE, residual[7:0]};
        if (phase == 2'd2) begin
            flush_word = {PAD_BYTE, PAD_BYTE, residual[15:0]};
        end
    end
`else
    logic [7:0] unused_pad;

    assign pixel_ready = out_free;
    assign unused_pad  = PAD_BYTE;
`endif

    assign accept = pixel_valid && pixel_ready;

    // Word assembled from the carried bytes and the incoming pixel, plus the new carry.
    always_comb begin
        emit          = 1'b1;
        norm_word     = '0;
        next_residual = '0;
        case (phase)
            2'd0: begin
                emit          = 1'b0;
                next_residual = pixel;
            end
            2'd1: begin
                norm_word     = {pixel[7:0], residual};
                next_residual = {8'h00, pixel[23:8]};
            end
            2'd2: begin
                norm_word     = {pixel[15:0], residual[15:0]};
                next_residual = {16'h0000, pixel[23:16]};
            end
            default: begin
                norm_word     = {pixel, residual[7:0]};
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            word       <= '0;
            word_valid <= 1'b0;
            word_last  <= 1'b0;
            phase      <= '0;
            residual   <= '0;
`ifdef RGB888_PACKER_PAD_EN
            state      <= RUN;
`endif
        end else begin
            if (word_valid && word_ready) begin
                word_valid <= 1'b0;
                word_last  <= 1'b0;
            end
`ifdef RGB888_PACKER_PAD_EN
            if (state == FLUSH) begin
                if (out_free) begin
                    word       <= flush_word;
                    word_valid <= 1'b1;
                    word_last  <= 1'b1;
                    phase      <= '0;
                    residual   <= '0;
                    state      <= RUN;
                end
            end else if (accept) begin
`else
            if (accept) begin
`endif
                if (emit) begin
                    word       <= norm_word;
                    word_valid <= 1'b1;
                    word_last  <= 1'b0;
                end
                phase    <= phase + 2'd1;
                residual <= next_residual;
                if (pixel_last) begin
`ifdef RGB888_PACKER_PAD_EN
                    case (phase)
                        2'd0: begin
                            word       <= {PAD_BYTE, pixel};
                            word_valid <= 1'b1;
                            word_last  <= 1'b1;
                            phase      <= '0;
                            residual   <= '0;
                        end
                        2'd3:    word_last <= 1'b1;
                        default: state     <= FLUSH;
                    endcase
`else
                    // Without flush, leftover bytes of a short line are dropped.
                    word_last <= emit;
                    phase     <= '0;
                    residual  <= '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb888_packer.sv
// tb_rgb888_packer: random and directed stimulus against a byte-queue reference model.
// Honours RGB888_PACKER_PAD_EN the same way as the design.
module tb_rgb888_packer;

    localparam logic [7:0] PAD = 8'h00;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [23:0] pixel;
    logic        pixel_valid;
    logic        pixel_last;
    logic        pixel_ready;
    logic [31:0] word;
    logic        word_valid;
    logic        word_last;
    logic        word_ready;

    int n_cmp = 0;
    int n_bad = 0;
    int stalls = 0;

    logic [7:0]  bq[$];
    logic [32:0] eq[$];
    logic [31:0] got[$];
    logic        got_last[$];
    logic        fl = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] hw;
    logic        hl;

    rgb888_packer #(.PAD_BYTE(PAD)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .pixel_last  (pixel_last),
        .pixel_ready (pixel_ready),
        .word        (word),
        .word_valid  (word_valid),
        .word_last   (word_last),
        .word_ready  (word_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int k);
        return {8'(3 * k + 3), 8'(3 * k + 2), 8'(3 * k + 1)};
    endfunction

    // Reference: a byte stream cut into little-endian 32-bit words; returns 1 if a flush follows.
    function automatic logic model_push(input logic [23:0] p, input logic last);
        logic [31:0] w;
        logic [32:0] t;
        logic        produced;
        logic        flush;
        produced = 1'b0;
        flush    = 1'b0;
        for (int b = 0; b < 3; b++) bq.push_back(p[8*b +: 8]);
        if (bq.size() >= 4) begin
            for (int b = 0; b < 4; b++) w[8*b +: 8] = bq.pop_front();
            eq.push_back({1'b0, w});
            produced = 1'b1;
        end
        if (last) begin
`ifdef RGB888_PACKER_PAD_EN
            if (bq.size() != 0) begin
                for (int b = 0; b < 4; b++) w[8*b +: 8] = (bq.size() != 0) ? bq.pop_front() : PAD;
                eq.push_back({1'b1, w});
                flush = produced;
            end else begin
                t = eq.pop_back();
                t[32] = 1'b1;
                eq.push_back(t);
            end
`else
            if (produced) begin
                t = eq.pop_back();
                t[32] = 1'b1;
                eq.push_back(t);
            end
            bq.delete();
`endif
        end
        return flush;
    endfunction

    task automatic step(input logic pv, input logic [23:0] p, input logic pl, input logic wr,
                        output logic acc);
        logic        tk;
        logic        nf;
        logic        ok;
        logic [32:0] e;
        pixel_valid = pv;
        pixel       = p;
        pixel_last  = pl;
        word_ready  = wr;
        #1;
        if (hold) begin
            check("hold_word", word, hw);
            check("hold_valid", 32'(word_valid), 32'd1);
            check("hold_last", 32'(word_last), 32'(hl));
        end
        check("pixel_ready", 32'(pixel_ready), 32'(!fl && (!word_valid || wr)));
        tk  = word_valid && wr;
        acc = pv && pixel_ready;
        if (pv && !pixel_ready) stalls++;
        if (tk) begin
            ok = (eq.size() != 0);
            check("word_expected", 32'(ok), 32'd1);
            if (ok) begin
                e = eq.pop_front();
                check("word", word, e[31:0]);
                check("word_last", 32'(word_last), 32'(e[32]));
            end
            got.push_back(word);
            got_last.push_back(word_last);
        end
        nf = fl;
        if (fl && (!word_valid || wr)) nf = 1'b0;
        hold = word_valid && !wr;
        hw   = word;
        hl   = word_last;
        if (acc && model_push(p, pl)) nf = 1'b1;
        fl = nf;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic send(input int n, input int base, input int bp_at, input int bp_len);
        int   idx;
        int   cyc;
        logic acc;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 200) begin
            step(1'b1, pix(base + idx), idx == n - 1, !(cyc >= bp_at && cyc < bp_at + bp_len), acc);
            if (acc) idx++;
            cyc++;
        end
        check("send_done", 32'(idx), 32'(n));
    endtask

    task automatic drain();
        logic acc;
        repeat (4) step(1'b0, 24'h0, 1'b0, 1'b1, acc);
        check("drained", 32'(eq.size()), 32'd0);
    endtask

    task automatic do_reset(input int n);
        reset_n     = 1'b0;
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;
        word_ready  = 1'b0;
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_last", 32'(word_last), 32'd0);
        check("rst_word", word, 32'd0);
        bq.delete();
        eq.delete();
        fl   = 1'b0;
        hold = 1'b0;
        reset_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(pixel_ready), 32'd1);
    endtask

    task automatic check_ref(input string tag, input int first);
        if (got.size() >= first + 3) begin
            check({tag, "_w0"}, got[first], 32'h04030201);
            check({tag, "_w1"}, got[first + 1], 32'h08070605);
            check({tag, "_w2"}, got[first + 2], 32'h0C0B0A09);
        end else begin
            check({tag, "_count"}, 32'(got.size()), 32'(first + 3));
        end
    endtask

    initial begin
        logic acc;
        reset_n     = 1'b0;
        pixel       = '0;
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;
        word_ready  = 1'b0;
        do_reset(3);

        // Full-rate streaming
        got.delete(); got_last.delete(); stalls = 0;
        send(8, 0, -1, 0);
        check("stream_stalls", 32'(stalls), 32'd0);
        drain();
        check("stream_words", 32'(got.size()), 32'd6);
        check_ref("stream", 0);
        if (got.size() == 6) check("stream_last", 32'(got_last[5]), 32'd1);

        // Output back-pressure mid-line
        got.delete(); got_last.delete(); stalls = 0;
        send(8, 8, 2, 5);
        check("bp_stalls", 32'(stalls), 32'd5);
        drain();
        check("bp_words", 32'(got.size()), 32'd6);
        if (got.size() == 6) check("bp_w0", got[0], 32'h1C1B1A19);

`ifdef RGB888_PACKER_PAD_EN
        got.delete(); got_last.delete();
        send(5, 0, -1, 0);
        drain();
        check("pad5_words", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            check("pad5_w3", got[3], 32'h000F0E0D);
            check("pad5_last", 32'(got_last[3]), 32'd1);
        end

        got.delete(); got_last.delete();
        send(6, 0, -1, 0);
        drain();
        check("pad6_words", 32'(got.size()), 32'd5);
        if (got.size() == 5) begin
            check("pad6_w3", got[3], 32'h100F0E0D);
            check("pad6_w3_last", 32'(got_last[3]), 32'd0);
            check("pad6_w4", got[4], 32'h00001211);
            check("pad6_last", 32'(got_last[4]), 32'd1);
        end
`else
        got.delete(); got_last.delete();
        send(6, 0, -1, 0);
        drain();
        check("trunc6_words", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            check("trunc6_w3", got[3], 32'h100F0E0D);
            check("trunc6_last", 32'(got_last[3]), 32'd1);
        end
`endif
        got.delete(); got_last.delete();
        send(4, 0, -1, 0);
        drain();
        check_ref("next_line", 0);

        // Reset mid-line with a word still pending
        got.delete(); got_last.delete();
        step(1'b1, pix(0), 1'b0, 1'b0, acc);
        step(1'b1, pix(1), 1'b0, 1'b0, acc);
        do_reset(1);
        check("midrst_none", 32'(got.size()), 32'd0);
        send(4, 0, -1, 0);
        drain();
        check_ref("after_rst", 0);
        if (got.size() == 3) check("after_rst_last", 32'(got_last[2]), 32'd1);

        // Random traffic with random line lengths and both-side stalls
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 24'($urandom), ($urandom % 6) == 0, ($urandom % 4) != 0, acc);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
